fetch_realign_buffer: RTL and testbench
=======================================

FETCH_REALIGN_BUFFER -- requirements
Module: fetch_realign_buffer

Interface
REQ-001 Parameter DEPTH, default 4: FIFO depth in 32-bit fetch words; power of two, at least 2.
REQ-002 Parameter BOOT_ADDR, default 32'h0000_0080: out_addr_o value after reset.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 clear_i  input  1  synchronous flush; restart fetch stream at flush_addr_i.
REQ-006 flush_addr_i  input  32  new stream address, halfword aligned; sampled when clear_i=1.
REQ-007 in_valid_i  input  1  fetch word valid.
REQ-008 in_rdata_i  input  32  fetch word, little-endian halfwords.
REQ-009 in_err_i  input  1  bus error for this fetch word.
REQ-010 in_ready_o  output  1  buffer accepts a word this cycle.
REQ-011 out_valid_o  output  1  a complete instruction is presented.
REQ-012 out_ready_i  input  1  consumer takes the instruction.
REQ-013 out_rdata_o  output  32  instruction; upper 16 bits don't-care when compressed.
REQ-014 out_addr_o  output  32  byte address of the presented instruction.
REQ-015 out_is_compressed_o  output  1  out_rdata_o[1:0] != 2'b11.
REQ-016 out_err_o  output  1  instruction contains errored fetch data.
REQ-017 out_err_plus2_o  output  1  only the upper halfword, taken from the second word, is errored.

Function
REQ-018 The FIFO shall store up to DEPTH {rdata, err} entries with wrapping read/write pointers and a count of 0..DEPTH.
REQ-019 A push shall occur on in_valid_i & in_ready_o; in_ready_o = (count < DEPTH), registered state only, with no dependence on out_ready_i.
REQ-020 The alignment FSM shall have states ALIGNED (instruction starts at head[15:0]) and UNALIGNED (instruction starts at head[31:16]).
REQ-021 ALIGNED: out_valid_o = (count >= 1); out_rdata_o = head word.
REQ-022 UNALIGNED, compressed: out_valid_o = (count >= 1); out_rdata_o[15:0] = head[31:16].
REQ-023 UNALIGNED, uncompressed: out_valid_o = (count >= 2); out_rdata_o = {head+1[15:0], head[31:16]}.
REQ-024 Fire (out_valid_o & out_ready_i) transitions:
- ALIGNED, compressed: go to UNALIGNED, no pop.
- ALIGNED, uncompressed: stay ALIGNED, pop 1 entry.
- UNALIGNED, compressed: go to ALIGNED, pop 1 entry.
- UNALIGNED, uncompressed: stay UNALIGNED, pop 1 entry.
REQ-025 On fire, out_addr_o shall advance by 2 (compressed) or 4 (uncompressed), modulo 2^32.
REQ-026 A push and a pop in the same cycle shall both take effect; count changes by push minus pop.
REQ-027 Latency from an accepted word to out_valid_o shall be 1 cycle; there is no combinational bypass.
REQ-028 out_err_o = OR of the err bits of every entry the instruction occupies.
REQ-029 out_err_plus2_o = 1 only in UNALIGNED, uncompressed, with head err=0 and head+1 err=1.
REQ-030 An errored head word shall be presented with out_valid_o=1 when its lower halfword alone forms an instruction.
REQ-031 clear_i shall win over push and fire in the same cycle:
- count := 0;
- out_addr_o := flush_addr_i with bit0 forced to 0;
- state := UNALIGNED if flush_addr_i[1] else ALIGNED;
- any concurrent push is dropped.
REQ-032 out_valid_o shall be 0 in the cycle after clear_i.

Reset
REQ-033 While rst_ni=0:
- count=0 and both pointers=0;
- state=ALIGNED;
- out_addr_o=BOOT_ADDR;
- out_valid_o=0, in_ready_o=1, out_err_o=0, out_err_plus2_o=0.
REQ-034 Reset asserted mid-operation shall discard all entries immediately, without waiting for a clock edge.

Configuration
REQ-035 Macro RV32C_EN compiles the compressed-instruction support in or out.
- Defined: behaviour as above.
- Undefined: out_is_compressed_o tied to 0, state held at ALIGNED, every fire pops 1 entry and advances out_addr_o by 4.
- Undefined, flush_addr_i[1]=1: the first output after the flush has out_err_o=1.

Structure
REQ-036 A shared package fetch_pkg shall hold:
- the alignment state enum;
- the FIFO entry struct {rdata[31:0], err};
- the localparam for the halfword width (16).
REQ-037 Storage shall be the sub-module fetch_fifo_mem (DEPTH-entry register array, write port, two read ports head/head+1); pointer and FSM logic stay in the top.

Verification
REQ-038 Push 32'h0001_4501, then 32'h0000_0513, at address 0x80 -> three outputs:
- 16'h4501 @0x80;
- 16'h0001 @0x82;
- 32'h0000_0513 @0x84.
REQ-039 Push 32'h0513_4505, then 32'h0000_0000 -> second output is 32'h0000_0513 @0x82 with out_valid_o asserted only after the second word is accepted.
REQ-040 Fill DEPTH words with out_ready_i=0 -> in_ready_o=0; one fire of an uncompressed instruction makes in_ready_o=1 in the next cycle; no word is lost or duplicated.
REQ-041 clear_i with flush_addr_i=0x0000_1002, concurrent with in_valid_i -> the word is dropped; the next word 32'h4505_xxxx yields 16'h4505 @0x1002.
REQ-042 Unaligned uncompressed instruction, second word in_err_i=1 -> out_err_o=1 and out_err_plus2_o=1; if the first word is errored instead -> out_err_plus2_o=0.
REQ-043 Assert rst_ni=0 while count=3 -> outputs take reset values in the same cycle; after release, out_addr_o=BOOT_ADDR.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch realign buffer: alignment state, FIFO entry, halfword width.
package fetch_pkg;

    localparam int unsigned HALF_W = 16;
    localparam int unsigned WORD_W = 2 * HALF_W;

    typedef enum logic {
        ALIGNED   = 1'b0,
        UNALIGNED = 1'b1
    } align_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] rdata;
        logic              err;
    } fetch_entry_t;

    // A halfword opens a 16-bit instruction unless its two low bits are both set.
    function automatic logic is_compressed(input logic [1:0] opcode_lo);
        return opcode_lo != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_fifo_mem.sv
// Fetch-word storage: DEPTH-entry register array, one write port, head and head+1 read ports.
module fetch_fifo_mem
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               we_i,
    input  logic [PTR_W-1:0]   waddr_i,
    input  fetch_entry_t       wdata_i,
    input  logic [PTR_W-1:0]   raddr0_i,
    input  logic [PTR_W-1:0]   raddr1_i,
    output fetch_entry_t       rdata0_o,
    output fetch_entry_t       rdata1_o
);

    fetch_entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/fetch_realign_buffer.sv
// Fetch FIFO that realigns a 32-bit word stream into 16/32-bit instructions.
// Compressed support is compiled in with the RV32C_EN macro.
module fetch_realign_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic [31:0] flush_addr_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        in_ready_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic [31:0] out_addr_o,
    output logic        out_is_compressed_o,
    output logic        out_err_o,
    output logic        out_err_plus2_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    align_state_e       state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        addr_step;
    fetch_entry_t       head, next;
    logic               push, pop, fire;
    logic               comp_lo, comp_hi;
    logic               flush_err;
    logic               unused_bits;

    fetch_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .we_i     (push),
        .waddr_i  (wr_ptr_q),
        .wdata_i  ('{rdata: in_rdata_i, err: in_err_i}),
        .raddr0_i (rd_ptr_q),
        .raddr1_i (rd_ptr_q + PTR_W'(1)),
        .rdata0_o (head),
        .rdata1_o (next)
    );

    // Flow control depends on registered occupancy only; a flush drops any concurrent word.
    assign in_ready_o = (count_q < CNT_W'(DEPTH));
    assign push       = in_valid_i & in_ready_o & ~clear_i;

`ifdef RV32C_EN
    assign comp_lo   = is_compressed(head.rdata[1:0]);
    assign comp_hi   = is_compressed(head.rdata[HALF_W+1:HALF_W]);
    assign flush_err = 1'b0;
`else
    logic misalign_err_q;

    // Without compressed support a flush to a halfword boundary cannot be honoured;
    // flag the first instruction fetched after it as errored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            misalign_err_q <= 1'b0;
        end else if (clear_i) begin
            misalign_err_q <= flush_addr_i[1];
        end else if (fire) begin
            misalign_err_q <= 1'b0;
        end
    end

    assign comp_lo   = 1'b0;
    assign comp_hi   = 1'b0;
    assign flush_err = misalign_err_q;
`endif

    // Alignment FSM: next state, pop/advance decisions and the presented instruction.
    always_comb begin
        state_d             = state_q;
        pop                 = 1'b0;
        fire                = 1'b0;
        addr_step           = '0;
        out_valid_o         = 1'b0;
        out_rdata_o         = head.rdata;
        out_is_compressed_o = 1'b0;
        out_err_o           = 1'b0;
        out_err_plus2_o     = 1'b0;

        case (state_q)
            ALIGNED: begin
                out_valid_o         = (count_q != '0);
                out_is_compressed_o = comp_lo;
                out_err_o           = out_valid_o & (head.err | flush_err);
                fire                = out_valid_o & out_ready_i;
                if (fire) begin
                    if (comp_lo) begin
                        state_d   = UNALIGNED;
                        addr_step = 32'd2;
                    end else begin
                        pop       = 1'b1;
                        addr_step = 32'd4;
                    end
                end
            end
            UNALIGNED: begin
                out_rdata_o         = {next.rdata[HALF_W-1:0], head.rdata[WORD_W-1:HALF_W]};
                out_is_compressed_o = comp_hi;
                if (comp_hi) begin
                    out_valid_o = (count_q != '0);
                    out_err_o   = out_valid_o & head.err;
                end else begin
                    out_valid_o     = (count_q >= CNT_W'(2));
                    out_err_o       = out_valid_o & (head.err | next.err);
                    out_err_plus2_o = out_valid_o & ~head.err & next.err;
                end
                fire = out_valid_o & out_ready_i;
                if (fire) begin
                    pop = 1'b1;
                    if (comp_hi) begin
                        state_d   = ALIGNED;
                        addr_step = 32'd2;
                    end else begin
                        addr_step = 32'd4;
                    end
                end
            end
            default: ;
        endcase

        if (clear_i) begin
`ifdef RV32C_EN
            state_d = flush_addr_i[1] ? UNALIGNED : ALIGNED;
`else
            state_d = ALIGNED;
`endif
        end
    end

    // Pointer, occupancy and address next values; a flush overrides push and fire.
    always_comb begin
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        addr_d   = addr_q + addr_step;
        if (clear_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            addr_d   = {flush_addr_i[31:1], 1'b0};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ALIGNED;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            addr_q   <= BOOT_ADDR;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            addr_q   <= addr_d;
        end
    end

    assign out_addr_o = addr_q;

    // The upper halfword of head+1 and the flush address LSB are never needed.
    assign unused_bits = ^{next.rdata[WORD_W-1:HALF_W], flush_addr_i[0]};

endmodule

// File: tb/tb_fetch_realign_buffer.sv
// Scoreboard bench for fetch_realign_buffer; expectations follow the RV32C_EN build setting.
module tb_fetch_realign_buffer;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [31:0] flush_addr;
    logic        in_valid;
    logic [31:0] in_rdata;
    logic        in_err;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [31:0] out_addr;
    logic        out_is_c;
    logic        out_err;
    logic        out_err_p2;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] mask;
        logic [31:0] addr;
        logic        is_c;
        logic        err;
        logic        p2;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_realign_buffer #(
        .DEPTH     (DEPTH),
        .BOOT_ADDR (32'h0000_0080)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .clear_i             (clear),
        .flush_addr_i        (flush_addr),
        .in_valid_i          (in_valid),
        .in_rdata_i          (in_rdata),
        .in_err_i            (in_err),
        .in_ready_o          (in_ready),
        .out_valid_o         (out_valid),
        .out_ready_i         (out_ready),
        .out_rdata_o         (out_rdata),
        .out_addr_o          (out_addr),
        .out_is_compressed_o (out_is_c),
        .out_err_o           (out_err),
        .out_err_plus2_o     (out_err_p2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input logic [31:0] rdata, input logic [31:0] mask,
                              input logic [31:0] addr, input logic is_c,
                              input logic err, input logic p2);
        exp_t e;
        e.rdata = rdata; e.mask = mask; e.addr = addr;
        e.is_c = is_c; e.err = err; e.p2 = p2;
        sb.push_back(e);
    endtask

    // Monitor: every fire is compared against the oldest expected instruction.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h @%h expected none", out_rdata, out_addr);
            end else begin
                e = sb.pop_front();
                chk("out_rdata", out_rdata & e.mask, e.rdata);
                chk("out_addr", out_addr, e.addr);
                chk("out_is_compressed", 32'(out_is_c), 32'(e.is_c));
                chk("out_err", 32'(out_err), 32'(e.err));
                chk("out_err_plus2", 32'(out_err_p2), 32'(e.p2));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input logic [31:0] a);
        clear      = 1'b1;
        flush_addr = a;
        tick();
        clear      = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d, input logic e);
        int n = 0;
        in_valid = 1'b1;
        in_rdata = d;
        in_err   = e;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("push_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_err   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        rst_n = 1'b0; clear = 1'b0; flush_addr = '0;
        in_valid = 1'b0; in_rdata = '0; in_err = 1'b0; out_ready = 1'b0;

        // Reset values
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_out_err_plus2", 32'(out_err_p2), 32'd0);
        chk("rst_out_addr", out_addr, 32'h0000_0080);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_addr", out_addr, 32'h0000_0080);

        // Mixed compressed / uncompressed stream from the boot address
        out_ready = 1'b1;
`ifdef RV32C_EN
        expect_out(32'h0000_4501, 32'h0000_FFFF, 32'h80, 1'b1, 1'b0, 1'b0);
        expect_out(32'h0000_0001, 32'h0000_FFFF, 32'h82, 1'b1, 1'b0, 1'b0);
        expect_out(32'h0000_0513, 32'hFFFF_FFFF, 32'h84, 1'b0, 1'b0, 1'b0);
`else
        expect_out(32'h0001_4501, 32'hFFFF_FFFF, 32'h80, 1'b0, 1'b0, 1'b0);
        expect_out(32'h0000_0513, 32'hFFFF_FFFF, 32'h84, 1'b0, 1'b0, 1'b0);
`endif
        push_word(32'h0001_4501, 1'b0);
        push_word(32'h0000_0513, 1'b0);
        drain();
        chk("t2_idle_valid", 32'(out_valid), 32'd0);

        // Instruction straddling two words waits for the second word
        do_clear(32'h80);
        chk("t3_clear_valid", 32'(out_valid), 32'd0);
`ifdef RV32C_EN
        expect_out(32'h0000_4505, 32'h0000_FFFF, 32'h80, 1'b1, 1'b0, 1'b0);
        expect_out(32'h0000_0513, 32'hFFFF_FFFF, 32'h82, 1'b0, 1'b0, 1'b0);
        expect_out(32'h0000_0000, 32'h0000_FFFF, 32'h86, 1'b1, 1'b0, 1'b0);
`else
        expect_out(32'h0513_4505, 32'hFFFF_FFFF, 32'h80, 1'b0, 1'b0, 1'b0);
        expect_out(32'h0000_0000, 32'hFFFF_FFFF, 32'h84, 1'b0, 1'b0, 1'b0);
`endif
        push_word(32'h0513_4505, 1'b0);
        tick();
        tick();
        chk("t3_wait_second_word", 32'(out_valid), 32'd0);
        push_word(32'h0000_0000, 1'b0);
        drain();

        // Fill to DEPTH with consumer stalled, then one fire frees a slot
        out_ready = 1'b0;
        do_clear(32'h100);
        chk("t4_clear_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            w = 32'h0000_1003 | (32'(i + 1) << 16);
            expect_out(w, 32'hFFFF_FFFF, 32'h100 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
            push_word(w, 1'b0);
            if (i == 0) chk("t4_latency_valid", 32'(out_valid), 32'd1);
        end
        chk("t4_full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_rdata = 32'hBAD0_BAD3;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_after_fire_in_ready", 32'(in_ready), 32'd1);
        expect_out(32'h0005_1003, 32'hFFFF_FFFF, 32'h110, 1'b0, 1'b0, 1'b0);
        push_word(32'h0005_1003, 1'b0);
        out_ready = 1'b1;
        drain();

        // Flush wins over a concurrent push; stream restarts at 0x1002
        clear      = 1'b1;
        flush_addr = 32'h0000_1002;
        in_valid   = 1'b1;
        in_rdata   = 32'hDEAD_BEEF;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("t5_clear_valid", 32'(out_valid), 32'd0);
`ifdef RV32C_EN
        expect_out(32'h0000_4505, 32'h0000_FFFF, 32'h1002, 1'b1, 1'b0, 1'b0);
        expect_out(32'h0000_0013, 32'hFFFF_FFFF, 32'h1004, 1'b0, 1'b0, 1'b0);
`else
        expect_out(32'h4505_1234, 32'hFFFF_FFFF, 32'h1002, 1'b0, 1'b1, 1'b0);
        expect_out(32'h0000_0013, 32'hFFFF_FFFF, 32'h1006, 1'b0, 1'b0, 1'b0);
`endif
        push_word(32'h4505_1234, 1'b0);
        push_word(32'h0000_0013, 1'b0);
        drain();

        // Error attribution across a word boundary
`ifdef RV32C_EN
        do_clear(32'h202);
        expect_out(32'h0000_0013, 32'hFFFF_FFFF, 32'h202, 1'b0, 1'b1, 1'b1);
        expect_out(32'h0000_0000, 32'h0000_FFFF, 32'h206, 1'b1, 1'b1, 1'b0);
        push_word(32'h0013_0000, 1'b0);
        push_word(32'h0000_0000, 1'b1);
        drain();
        do_clear(32'h302);
        expect_out(32'h0000_0013, 32'hFFFF_FFFF, 32'h302, 1'b0, 1'b1, 1'b0);
        expect_out(32'h0000_0000, 32'h0000_FFFF, 32'h306, 1'b1, 1'b0, 1'b0);
        push_word(32'h0013_0000, 1'b1);
        push_word(32'h0000_0000, 1'b0);
        drain();
`else
        do_clear(32'h200);
        expect_out(32'h0013_0000, 32'hFFFF_FFFF, 32'h200, 1'b0, 1'b0, 1'b0);
        expect_out(32'h0000_0000, 32'hFFFF_FFFF, 32'h204, 1'b0, 1'b1, 1'b0);
        push_word(32'h0013_0000, 1'b0);
        push_word(32'h0000_0000, 1'b1);
        drain();
        do_clear(32'h300);
        expect_out(32'h0013_0000, 32'hFFFF_FFFF, 32'h300, 1'b0, 1'b1, 1'b0);
        expect_out(32'h0000_0000, 32'hFFFF_FFFF, 32'h304, 1'b0, 1'b0, 1'b0);
        push_word(32'h0013_0000, 1'b1);
        push_word(32'h0000_0000, 1'b0);
        drain();
`endif

        // Address wraps modulo 2^32
        do_clear(32'hFFFF_FFFC);
        expect_out(32'h0000_0013, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        expect_out(32'h0000_0093, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        push_word(32'h0000_0013, 1'b0);
        push_word(32'h0000_0093, 1'b0);
        drain();

        // Asynchronous reset with three words buffered
        out_ready = 1'b0;
        do_clear(32'h400);
        push_word(32'h0000_0013, 1'b0);
        push_word(32'h0000_0093, 1'b0);
        push_word(32'h0000_0113, 1'b0);
        chk("t7_pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_async_valid", 32'(out_valid), 32'd0);
        chk("t7_async_in_ready", 32'(in_ready), 32'd1);
        chk("t7_async_addr", out_addr, 32'h0000_0080);
        chk("t7_async_err", 32'(out_err), 32'd0);
        chk("t7_async_err_plus2", 32'(out_err_p2), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("t7_release_addr", out_addr, 32'h0000_0080);
        chk("t7_release_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        expect_out(32'h0000_0213, 32'hFFFF_FFFF, 32'h80, 1'b0, 1'b0, 1'b0);
        push_word(32'h0000_0213, 1'b0);
        drain();

        tick();
        chk("final_queue_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
